// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response bundle for the sequential ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output start, op, srcA, srcB,
        input  busy, done, result, hi, lo, zero, overflow, div_by_zero
    );

    modport slave (
        input  start, op, srcA, srcB,
        output busy, done, result, hi, lo, zero, overflow, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : ALU with single-cycle logic/arith ops, shift-add MULTU and
//                restoring DIVU (one bit per clock).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MULTU = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               ovf_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;

    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_ovf_d;
    logic               alu_nop_d;
    logic [WIDTH-1:0]   add_d;
    logic [WIDTH-1:0]   sub_d;
    logic [WIDTH:0]     mul_sum_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH:0]     div_shift_d;
    logic               div_ge_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic               last_iter_d;

    always_comb begin
        add_d     = bus.srcA + bus.srcB;
        sub_d     = bus.srcA - bus.srcB;
        alu_res_d = '0;
        alu_ovf_d = 1'b0;
        alu_nop_d = 1'b0;
        case (bus.op)
            OP_AND:  alu_res_d = bus.srcA & bus.srcB;
            OP_OR:   alu_res_d = bus.srcA | bus.srcB;
            OP_ADD: begin
                alu_res_d = add_d;
                alu_ovf_d = (bus.srcA[WIDTH-1] == bus.srcB[WIDTH-1]) &&
                            (add_d[WIDTH-1] != bus.srcA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_d = sub_d;
                alu_ovf_d = (bus.srcA[WIDTH-1] != bus.srcB[WIDTH-1]) &&
                            (sub_d[WIDTH-1] != bus.srcA[WIDTH-1]);
            end
            OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.srcA) < $signed(bus.srcB))};
            OP_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, (bus.srcA < bus.srcB)};
            default: alu_nop_d = 1'b1;
        endcase
    end

    // Shift-add step: conditionally add multiplicand to the upper half, then shift right.
    // Restoring step: shift next dividend bit into the remainder, subtract if it fits.
    // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
    always_comb begin
        mul_sum_d   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
        prod_d      = {mul_sum_d, prod_q[WIDTH-1:1]};
        div_shift_d = {rem_q, quo_q[WIDTH-1]};
        div_ge_d    = (div_shift_d >= {1'b0, opb_q});
        rem_d       = div_ge_d ? (div_shift_d[WIDTH-1:0] - opb_q) : div_shift_d[WIDTH-1:0];
        quo_d       = {quo_q[WIDTH-2:0], div_ge_d};
        last_iter_d = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt_q <= '0;
                        ovf_q <= alu_ovf_d;
                        if (bus.op == OP_MULTU) begin
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
                            opa_q   <= bus.srcA;
                            prod_q  <= {{WIDTH{1'b0}}, bus.srcB};
                        end else if (bus.op == OP_DIVU) begin
                            state_q <= ST_DIV;
                            busy_q  <= 1'b1;
                            opb_q   <= bus.srcB;
                            quo_q   <= bus.srcA;
                            rem_q   <= '0;
                        end else begin
                            result_q <= alu_res_d;
                            done_q   <= 1'b1;
                            if (alu_nop_d) begin
                                dbz_q <= 1'b0;
                            end
                        end
                    end
                end
                ST_MUL: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_iter_d) begin
                        hi_q    <= prod_d[2*WIDTH-1:WIDTH];
                        lo_q    <= prod_d[WIDTH-1:0];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter_d) begin
                        hi_q    <= rem_d;
                        lo_q    <= quo_d;
                        dbz_q   <= (opb_q == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.zero        = (result_q == '0);
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8..64, even.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  operation request, sampled on rising clk.
REQ-005 op  input  4  operation code, sampled with start.
REQ-006 srcA, srcB  input  WIDTH each  operands, sampled with start.
REQ-007 busy  output  1  high while a multi-cycle operation is in progress.
REQ-008 done  output  1  one-cycle pulse: result, hi, lo and flags valid this cycle.
REQ-009 result  output  WIDTH  registered result of the last single-cycle op.
REQ-010 hi, lo  output  WIDTH each  registered MULTU product halves or DIVU remainder/quotient.
REQ-011 zero  output  1  high when result equals 0.
REQ-012 overflow  output  1  signed overflow of the last ADD/SUB.
REQ-013 div_by_zero  output  1  last DIVU had srcB == 0.

Function
REQ-014 Op codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0101 SLTU, 0011 MULTU, 0100 DIVU; any other code is NOP.
REQ-015 The FSM SHALL have states IDLE, MUL, DIV; start is accepted only when busy == 0 (IDLE, including the cycle done is high).
REQ-016 A start with busy == 1 SHALL be ignored without affecting the operation in progress.
REQ-017 Single-cycle ops (AND, OR, ADD, SUB, SLT, SLTU, NOP) SHALL register result on the accepting edge and pulse done in the next cycle; FSM stays IDLE; hi/lo unchanged.
REQ-018 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow = signed overflow; overflow SHALL be cleared by every other op.
REQ-019 SLT/SLTU SHALL set result to 1 if srcA < srcB (signed/unsigned), else 0, zero-extended to WIDTH.
REQ-020 NOP SHALL set result to 0, pulse done, and clear overflow and div_by_zero.
REQ-021 MULTU SHALL be shift-add, one iteration per clk: enter MUL on the accepting edge, run WIDTH iterations, then write {hi,lo} = srcA*srcB (unsigned, 2*WIDTH bits) and pulse done; total latency WIDTH+1 cycles from acceptance to done.
REQ-022 DIVU SHALL be restoring division, one quotient bit per clk, same latency as MULTU; lo = quotient, hi = remainder.
REQ-023 DIVU with srcB == 0 SHALL run full latency and yield lo = all ones, hi = srcA, div_by_zero = 1; otherwise div_by_zero = 0.
REQ-024 busy SHALL be high from the cycle after the accepting edge until the completing edge; it is low in the done cycle.
REQ-025 result and zero SHALL hold during and after MULTU/DIVU; hi/lo SHALL hold between writes.
REQ-026 Operands SHALL be captured at acceptance; changes to srcA/srcB/op during busy SHALL have no effect.
REQ-027 Iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap within an operation.

Reset
REQ-028 reset SHALL immediately force IDLE, counter 0, busy 0, done 0, result 0, hi 0, lo 0, overflow 0, div_by_zero 0; zero = 1.
REQ-029 reset during MUL/DIV SHALL abort the operation with no done pulse; first start after reset deasserts is accepted normally.

Verification (WIDTH = 32)
REQ-030 ADD 0x7FFFFFFF + 1 -> done next cycle, result 0x80000000, overflow 1, zero 0; then SUB 5 - 5 -> result 0, zero 1, overflow 0.
REQ-031 SLT 0xFFFFFFFF vs 1 -> result 1; SLTU same operands -> result 0, zero 1.
REQ-032 MULTU 0xFFFFFFFF * 2 -> busy 32 cycles, done at cycle 33, hi 0x00000001, lo 0xFFFFFFFE; start asserted mid-operation ignored.
REQ-033 DIVU 100 / 7 -> lo 14, hi 2, div_by_zero 0; DIVU 0x1234 / 0 -> lo 0xFFFFFFFF, hi 0x1234, div_by_zero 1.
REQ-034 reset asserted at cycle 10 of a MULTU -> all outputs zero immediately except zero = 1, no done; subsequent ADD 3 + 4 -> result 7.
REQ-035 Back-to-back: start held with DIVU then ADD 1 + 1 during done cycle -> ADD accepted, result 2 one cycle later, hi/lo keep DIVU values.
